// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: major opcodes, operation classes,
// operation codes and the decoded record layout.
package issue_queue_pkg;

  // RV32 major opcodes (ins[6:0])
  localparam logic [6:0] MOP_R     = 7'b0110011;
  localparam logic [6:0] MOP_I_ALU = 7'b0010011;
  localparam logic [6:0] MOP_LOAD  = 7'b0000011;
  localparam logic [6:0] MOP_STORE = 7'b0100011;
  localparam logic [6:0] MOP_BRA   = 7'b1100011;
  localparam logic [6:0] MOP_JALR  = 7'b1100111;
  localparam logic [6:0] MOP_JAL   = 7'b1101111;
  localparam logic [6:0] MOP_AUIPC = 7'b0010111;
  localparam logic [6:0] MOP_LUI   = 7'b0110111;

  // Operation classes; zero is reserved for the illegal/empty record
  localparam logic [3:0] OPT_NONE = 4'd0;
  localparam logic [3:0] OPT_CAL  = 4'd1;
  localparam logic [3:0] OPT_CALI = 4'd2;
  localparam logic [3:0] OPT_LAD  = 4'd3;
  localparam logic [3:0] OPT_STR  = 4'd4;
  localparam logic [3:0] OPT_BRA  = 4'd5;
  localparam logic [3:0] OPT_JUM  = 4'd6;

  // Operation codes that are not {bit30, funct3}; AUIPC/LUI sit above the
  // largest CALi funct-derived code (4'b1101) so they never collide.
  localparam logic [3:0] OPC_JAL   = 4'h0;
  localparam logic [3:0] OPC_JALR  = 4'h1;
  localparam logic [3:0] OPC_AUIPC = 4'hE;
  localparam logic [3:0] OPC_LUI   = 4'hF;

  // Decoded record; imm is the 32-bit extended immediate, widened at the output
  typedef struct packed {
    logic        rs1_hv;
    logic        rs2_hv;
    logic        rd_hv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  opcode;
    logic [3:0]  optype;
    logic        illegal;
  } dec_t;

  // All-zero record: base of every decode and the value shown when empty
  localparam dec_t REC_ZERO = '0;

endpackage

// File: rtl/issue_queue_if.sv
// Fetch-side and dispatch-side handshake bundle of the issue queue.
interface issue_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [31:0]     in_ins;
  logic [XLEN-1:0] in_pc;
  logic            in_ready;

  logic            out_valid;
  logic            out_ready;
  logic            out_rs1_hv;
  logic            out_rs2_hv;
  logic            out_rd_hv;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      out_opcode;
  logic [3:0]      out_optype;
  logic            out_illegal;

  // Queue side
  modport slave (
    input  in_valid, in_ins, in_pc, out_ready,
    output in_ready, out_valid, out_rs1_hv, out_rs2_hv, out_rd_hv,
           out_rs1, out_rs2, out_rd, out_imm, out_pc, out_opcode,
           out_optype, out_illegal
  );

  // Fetch/dispatch side
  modport master (
    output in_valid, in_ins, in_pc, out_ready,
    input  in_ready, out_valid, out_rs1_hv, out_rs2_hv, out_rd_hv,
           out_rs1, out_rs2, out_rd, out_imm, out_pc, out_opcode,
           out_optype, out_illegal
  );
endinterface

// File: rtl/issue_queue_decode.sv
// Combinational RV32 instruction decoder producing one queue record.
module issue_decode
  import issue_queue_pkg::*;
(
  input  logic [31:0] ins,
  output dec_t        rec,
  output logic        illegal
);

  logic [2:0] f3;
  assign f3 = ins[14:12];

  // Decode by major opcode; unsupported opcodes leave the zero record flagged illegal
  always_comb begin
    rec = REC_ZERO;
    case (ins[6:0])
      MOP_R: begin
        rec.optype = OPT_CAL;
        rec.opcode = {ins[30], f3};
        rec.rs1_hv = 1'b1;
        rec.rs2_hv = 1'b1;
        rec.rd_hv  = 1'b1;
      end
      MOP_I_ALU: begin
        rec.optype = OPT_CALI;
        rec.rs1_hv = 1'b1;
        rec.rd_hv  = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          rec.imm    = {27'd0, ins[24:20]};
          rec.opcode = {ins[30], f3};
        end else begin
          rec.imm    = {{20{ins[31]}}, ins[31:20]};
          rec.opcode = {1'b0, f3};
        end
      end
      MOP_LOAD: begin
        rec.optype = OPT_LAD;
        rec.opcode = {1'b0, f3};
        rec.rs1_hv = 1'b1;
        rec.rd_hv  = 1'b1;
        rec.imm    = {{20{ins[31]}}, ins[31:20]};
      end
      MOP_STORE: begin
        rec.optype = OPT_STR;
        rec.opcode = {1'b0, f3};
        rec.rs1_hv = 1'b1;
        rec.rs2_hv = 1'b1;
        rec.imm    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      MOP_BRA: begin
        rec.optype = OPT_BRA;
        rec.opcode = {1'b0, f3};
        rec.rs1_hv = 1'b1;
        rec.rs2_hv = 1'b1;
        rec.imm    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      MOP_JALR: begin
        rec.optype = OPT_JUM;
        rec.opcode = OPC_JALR;
        rec.rs1_hv = 1'b1;
        rec.rd_hv  = 1'b1;
        rec.imm    = {{20{ins[31]}}, ins[31:20]};
      end
      MOP_JAL: begin
        rec.optype = OPT_JUM;
        rec.opcode = OPC_JAL;
        rec.rd_hv  = 1'b1;
        rec.imm    = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      MOP_AUIPC: begin
        rec.optype = OPT_CALI;
        rec.opcode = OPC_AUIPC;
        rec.rd_hv  = 1'b1;
        rec.imm    = {ins[31:12], 12'h000};
      end
      MOP_LUI: begin
        rec.optype = OPT_CALI;
        rec.opcode = OPC_LUI;
        rec.rd_hv  = 1'b1;
        rec.imm    = {ins[31:12], 12'h000};
      end
      default: begin
        rec.illegal = 1'b1;
      end
    endcase
    // Register indices are only meaningful where the operand is present
    rec.rs1 = rec.rs1_hv ? ins[19:15] : 5'd0;
    rec.rs2 = rec.rs2_hv ? ins[24:20] : 5'd0;
    rec.rd  = rec.rd_hv  ? ins[11:7]  : 5'd0;
  end

  assign illegal = rec.illegal;

endmodule

// File: rtl/issue_queue.sv
// Decode-and-buffer stage: decodes fetched instructions and holds the
// records in a circular FIFO presented in order to dispatch.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int XLEN   = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  issue_queue_if.slave      q,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  dec_t              rec_mem [DEPTH];
  logic [XLEN-1:0]   pc_mem  [DEPTH];

  dec_t in_rec;
  dec_t head_rec;
  logic in_illegal;
  logic push;
  logic pop;

  issue_decode u_decode (
    .ins     (q.in_ins),
    .rec     (in_rec),
    .illegal (in_illegal)
  );

  // Handshake readiness depends only on the registered occupancy
  assign q.in_ready  = (count != FULL);
  assign q.out_valid = (count != '0);

  assign push = q.in_valid  & q.in_ready & rdy_in & ~flush_in;
  assign pop  = q.out_valid & q.out_ready & rdy_in & ~flush_in;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Record storage; contents are not reset since occupancy gates visibility
  always_ff @(posedge clk_in) begin
    if (!rst_in && push) begin
      rec_mem[tail] <= in_rec;
      pc_mem[tail]  <= q.in_pc;
    end
  end

  // Head read, forced to zero while the queue is empty
  always_comb begin
    head_rec = REC_ZERO;
    q.out_pc = '0;
    if (q.out_valid) begin
      head_rec = rec_mem[head];
      q.out_pc = pc_mem[head];
    end
  end

  assign q.out_rs1_hv  = head_rec.rs1_hv;
  assign q.out_rs2_hv  = head_rec.rs2_hv;
  assign q.out_rd_hv   = head_rec.rd_hv;
  assign q.out_rs1     = head_rec.rs1;
  assign q.out_rs2     = head_rec.rs2;
  assign q.out_rd      = head_rec.rd;
  assign q.out_imm     = XLEN'(signed'(head_rec.imm));
  assign q.out_opcode  = head_rec.opcode;
  assign q.out_optype  = head_rec.optype;
  assign q.out_illegal = head_rec.illegal;

  logic unused_ok;
  assign unused_ok = in_illegal;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with a small FIFO scoreboard of pc/imm.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int AW    = 4;
  localparam int XL    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          flush;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  issue_queue_if #(.XLEN(XL)) bus ();

  issue_queue #(.ADDR_W(AW), .XLEN(XL)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .rdy_in   (rdy),
    .flush_in (flush),
    .q        (bus),
    .count    (count)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] q_pc  [$];
  logic [31:0] q_imm [$];
  logic [31:0] hold_pc;
  logic [31:0] hold_imm;
  logic [AW:0] hold_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADDI x1,x1,k with small positive k, so the expected immediate is k
  function automatic logic [31:0] addi(input int k);
    return {k[11:0], 5'd1, 3'b000, 5'd1, 7'h13};
  endfunction

  // One clock of stimulus, checked against the scoreboard
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] eimm, input logic ordy, input logic r, input logic fl);
    logic mpush, mpop;
    bus.in_valid  = iv;
    bus.in_ins    = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    rdy           = r;
    flush         = fl;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(q_pc.size() != DEPTH));
    chk("out_valid", 64'(bus.out_valid), 64'(q_pc.size() != 0));
    mpush = iv && (q_pc.size() != DEPTH) && r && !fl;
    mpop  = (q_pc.size() != 0) && ordy && r && !fl;
    if (mpop) begin
      chk("pop_pc", 64'(bus.out_pc), 64'(q_pc[0]));
      chk("pop_imm", 64'(bus.out_imm), 64'(q_imm[0]));
    end
    @(posedge clk);
    #1;
    if (r && fl) begin
      q_pc.delete();
      q_imm.delete();
    end else begin
      if (mpop) begin
        void'(q_pc.pop_front());
        void'(q_imm.pop_front());
      end
      if (mpush) begin
        q_pc.push_back(pc);
        q_imm.push_back(eimm);
      end
    end
    chk("count", 64'(count), 64'(q_pc.size()));
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_ins    = addi(5);
    bus.in_pc     = 32'h40;
    bus.out_ready = 1'b0;
    rdy           = 1'b1;
    flush         = 1'b1;
    rst           = 1'b1;

    // Reset wins over an offered push and a flush
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_optype", 64'(bus.out_optype), 64'd0);

    // ADDI x1,x0,-1
    cyc(1'b1, 32'hFFF0_0093, 32'h100, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    chk("addi_valid", 64'(bus.out_valid), 64'd1);
    chk("addi_optype", 64'(bus.out_optype), 64'(OPT_CALI));
    chk("addi_rd", 64'(bus.out_rd), 64'd1);
    chk("addi_imm", 64'(bus.out_imm), 64'hFFFF_FFFF);
    chk("addi_rs2_hv", 64'(bus.out_rs2_hv), 64'd0);
    chk("addi_pc", 64'(bus.out_pc), 64'h100);
    chk("addi_opcode", 64'(bus.out_opcode), 64'd0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

    // SUB x3,x1,x2
    cyc(1'b1, 32'h4020_81B3, 32'h104, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("sub_optype", 64'(bus.out_optype), 64'(OPT_CAL));
    chk("sub_opcode", 64'(bus.out_opcode), 64'h8);
    chk("sub_rs2", 64'(bus.out_rs2), 64'd2);
    chk("sub_hv", 64'({bus.out_rs1_hv, bus.out_rs2_hv, bus.out_rd_hv}), 64'b111);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

    // SW x2,8(x1)
    cyc(1'b1, 32'h0020_A423, 32'h108, 32'h8, 1'b0, 1'b1, 1'b0);
    chk("sw_optype", 64'(bus.out_optype), 64'(OPT_STR));
    chk("sw_opcode", 64'(bus.out_opcode), 64'd2);
    chk("sw_hv", 64'({bus.out_rs1_hv, bus.out_rs2_hv, bus.out_rd_hv}), 64'b110);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

    // BEQ x0,x0,-4
    cyc(1'b1, 32'hFE00_0EE3, 32'h10C, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    chk("beq_optype", 64'(bus.out_optype), 64'(OPT_BRA));
    chk("beq_rd_hv", 64'(bus.out_rd_hv), 64'd0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

    // JAL x1,+8 and LUI x5,0x12345
    cyc(1'b1, 32'h0080_00EF, 32'h110, 32'h8, 1'b0, 1'b1, 1'b0);
    chk("jal_optype", 64'(bus.out_optype), 64'(OPT_JUM));
    chk("jal_opcode", 64'(bus.out_opcode), 64'(OPC_JAL));
    chk("jal_hv", 64'({bus.out_rs1_hv, bus.out_rs2_hv, bus.out_rd_hv}), 64'b001);
    cyc(1'b1, 32'h1234_52B7, 32'h114, 32'h1234_5000, 1'b1, 1'b1, 1'b0);
    chk("lui_opcode", 64'(bus.out_opcode), 64'(OPC_LUI));
    chk("lui_rd", 64'(bus.out_rd), 64'd5);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("empty_imm", 64'(bus.out_imm), 64'd0);

    // Fill to DEPTH with dispatch stalled
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, addi(i + 1), 32'h200 + 32'(4 * i), 32'(i + 1), 1'b0, 1'b1, 1'b0);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd16);
    cyc(1'b1, addi(99), 32'h999, 32'd99, 1'b0, 1'b1, 1'b0);
    // Pop while full with a push offered: no same-cycle slot reuse
    cyc(1'b1, addi(98), 32'h998, 32'd98, 1'b1, 1'b1, 1'b0);
    drain();
    chk("drained_valid", 64'(bus.out_valid), 64'd0);

    // Mixed traffic across pointer wrap
    for (int i = 0; i < 40; i++)
      cyc(((i % 4) != 3), addi(i + 200), 32'h400 + 32'(4 * i), 32'(i + 200),
          ((i % 3) != 0), 1'b1, 1'b0);
    drain();

    // Steady state at count = 3
    for (int i = 0; i < 3; i++)
      cyc(1'b1, addi(i + 300), 32'h600 + 32'(4 * i), 32'(i + 300), 1'b0, 1'b1, 1'b0);
    for (int i = 3; i < 23; i++) begin
      cyc(1'b1, addi(i + 300), 32'h600 + 32'(4 * i), 32'(i + 300), 1'b1, 1'b1, 1'b0);
      chk("steady_count", 64'(count), 64'd3);
    end
    drain();

    // Flush with an instruction offered in the same cycle
    for (int i = 0; i < 5; i++)
      cyc(1'b1, addi(i + 50), 32'h700 + 32'(4 * i), 32'(i + 50), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, addi(77), 32'h777, 32'd77, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    cyc(1'b1, addi(78), 32'h778, 32'd78, 1'b0, 1'b1, 1'b0);
    chk("post_flush_pc", 64'(bus.out_pc), 64'h778);
    drain();

    // Illegal opcode followed by SRAI x1,x1,2
    cyc(1'b1, 32'h0000_007F, 32'h800, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h4020_D093, 32'h804, 32'h2, 1'b0, 1'b1, 1'b0);
    chk("ill_flag", 64'(bus.out_illegal), 64'd1);
    chk("ill_hv", 64'({bus.out_rs1_hv, bus.out_rs2_hv, bus.out_rd_hv}), 64'd0);
    chk("ill_imm", 64'(bus.out_imm), 64'd0);
    chk("ill_optype", 64'(bus.out_optype), 64'd0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("srai_opcode", 64'(bus.out_opcode), 64'hD);
    chk("srai_imm", 64'(bus.out_imm), 64'd2);
    chk("srai_illegal", 64'(bus.out_illegal), 64'd0);
    chk("srai_optype", 64'(bus.out_optype), 64'(OPT_CALI));
    drain();

    // Global stall during traffic
    for (int i = 0; i < 4; i++)
      cyc(1'b1, addi(i + 500), 32'h900 + 32'(4 * i), 32'(i + 500), (i > 1), 1'b1, 1'b0);
    hold_pc  = bus.out_pc;
    hold_imm = bus.out_imm;
    hold_cnt = count;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, addi(i + 600), 32'hA00 + 32'(4 * i), 32'(i + 600), 1'b1, 1'b0, 1'b0);
      chk("hold_pc", 64'(bus.out_pc), 64'(hold_pc));
      chk("hold_imm", 64'(bus.out_imm), 64'(hold_imm));
      chk("hold_count", 64'(count), 64'(hold_cnt));
    end
    for (int i = 0; i < 6; i++)
      cyc((i < 3), addi(i + 700), 32'hB00 + 32'(4 * i), 32'(i + 700), 1'b1, 1'b1, 1'b0);
    drain();
    chk("final_valid", 64'(bus.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
